// File: rtl/sfq_not_stim_driver.sv
// Synchronous-to-SFQ transmitter for a clocked RSFQ NOT cell: FIFO-buffered bits become toggle-encoded
// a/clk pulses with fixed setup/hold spacing. Optional q-pulse checker built when SFQ_NOT_CHECK_EN is defined.
module sfq_not_stim_driver #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned HOLD_CYC  = 4,
   parameter int unsigned Q_WIN_CYC = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_bit,
   output logic        sfq_a,
   output logic        sfq_clk,
   input  logic        sfq_q,
   output logic        busy,
   output logic [15:0] bits_sent,
   output logic [15:0] err_count
);

   localparam int unsigned AW     = $clog2(DEPTH);
   localparam int unsigned MaxCyc = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
   localparam int unsigned CntW   = $clog2(MaxCyc + 1);
   localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
   localparam logic [CntW-1:0] HoldLd  = CntW'(HOLD_CYC - 1);
   localparam logic [AW:0]     PtrOne  = 1;

   typedef enum logic [1:0] {StIdle, StSetup, StHold} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DEPTH-1:0]  mem_q, mem_d;
   logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic              bit_q, bit_d;
   logic              sfq_a_q, sfq_a_d;
   logic              sfq_clk_q, sfq_clk_d;
   logic [15:0]       bits_sent_q, bits_sent_d;
   logic              empty, full, push, pop, fire_clk, head;

   // Extra pointer MSB distinguishes full from empty.
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push     = in_valid & ~full;
   assign head     = mem_q[rd_ptr_q[AW-1:0]];
   assign in_ready = ~full;
   assign busy     = ~empty | (state_q != StIdle);
   assign sfq_a     = sfq_a_q;
   assign sfq_clk   = sfq_clk_q;
   assign bits_sent = bits_sent_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (!empty) state_d = StSetup;
         StSetup: if (cnt_q == '0) state_d = StHold;
         StHold:  if (cnt_q == '0) state_d = empty ? StIdle : StSetup;
         default: state_d = StIdle;
      endcase
   end

   // HOLD pops directly into SETUP so back-to-back bits keep a SETUP_CYC+HOLD_CYC period.
   always_comb begin
      pop      = 1'b0;
      fire_clk = 1'b0;
      cnt_d    = cnt_q;
      case (state_q)
         StIdle: begin
            if (!empty) begin
               pop   = 1'b1;
               cnt_d = SetupLd;
            end
         end
         StSetup: begin
            if (cnt_q == '0) begin
               fire_clk = 1'b1;
               cnt_d    = HoldLd;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StHold: begin
            if (cnt_q == '0) begin
               if (!empty) begin
                  pop   = 1'b1;
                  cnt_d = SetupLd;
               end
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: cnt_d = '0;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q[AW-1:0]] = in_bit;
      wr_ptr_d    = push ? wr_ptr_q + PtrOne : wr_ptr_q;
      rd_ptr_d    = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
      bit_d       = pop ? head : bit_q;
      sfq_a_d     = sfq_a_q ^ (pop & head);
      sfq_clk_d   = sfq_clk_q ^ fire_clk;
      bits_sent_d = bits_sent_q + {15'd0, fire_clk};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         mem_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         bit_q       <= 1'b0;
         sfq_a_q     <= 1'b0;
         sfq_clk_q   <= 1'b0;
         bits_sent_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         bit_q       <= bit_d;
         sfq_a_q     <= sfq_a_d;
         sfq_clk_q   <= sfq_clk_d;
         bits_sent_q <= bits_sent_d;
      end
   end

`ifdef SFQ_NOT_CHECK_EN
   localparam int unsigned WinW = $clog2(Q_WIN_CYC + 1);

   logic            sync1_q, sync2_q, sync3_q;
   logic [1:0]      ev_q, ev_d;
   logic [1:0]      exp_pipe_q, exp_pipe_d;
   logic [WinW-1:0] win_cnt_q, win_cnt_d;
   logic            win_seen_q, win_seen_d;
   logic            win_exp_q, win_exp_d;
   logic [15:0]     err_q, err_d;
   logic            q_edge, err_inc;

   assign q_edge    = sync2_q ^ sync3_q;
   assign err_count = err_q;

   // Window opening is delayed by the synchronizer depth so it lines up with synced q edges.
   always_comb begin
      ev_d       = {ev_q[0], fire_clk};
      exp_pipe_d = {exp_pipe_q[0], ~bit_q};
      win_cnt_d  = win_cnt_q;
      win_seen_d = win_seen_q;
      win_exp_d  = win_exp_q;
      err_inc    = 1'b0;
      if (ev_q[1]) begin
         win_cnt_d  = WinW'(Q_WIN_CYC);
         win_seen_d = 1'b0;
         win_exp_d  = exp_pipe_q[1];
         err_inc    = q_edge;
      end else if (win_cnt_q != '0) begin
         win_seen_d = win_seen_q | q_edge;
         win_cnt_d  = win_cnt_q - WinW'(1);
         if (win_cnt_q == WinW'(1)) err_inc = ((win_seen_q | q_edge) != win_exp_q);
      end else begin
         err_inc = q_edge;
      end
      err_d = (err_inc && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         sync3_q    <= 1'b0;
         ev_q       <= '0;
         exp_pipe_q <= '0;
         win_cnt_q  <= '0;
         win_seen_q <= 1'b0;
         win_exp_q  <= 1'b0;
         err_q      <= '0;
      end else begin
         sync1_q    <= sfq_q;
         sync2_q    <= sync1_q;
         sync3_q    <= sync2_q;
         ev_q       <= ev_d;
         exp_pipe_q <= exp_pipe_d;
         win_cnt_q  <= win_cnt_d;
         win_seen_q <= win_seen_d;
         win_exp_q  <= win_exp_d;
         err_q      <= err_d;
      end
   end
`else
   logic unused_chk;
   assign unused_chk = sfq_q ^ (Q_WIN_CYC == 0);
   assign err_count  = '0;
`endif

endmodule

// File: tb/tb_sfq_not_stim_driver.sv
// Self-checking bench for sfq_not_stim_driver: scoreboard of pushed bits checked against a/clk pulses.
module tb_sfq_not_stim_driver;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned SETUP  = 2;
   localparam int unsigned HOLD   = 4;
   localparam int unsigned QWIN   = 3;
   localparam int unsigned PERIOD = SETUP + HOLD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_bit = 1'b0;
   logic        sfq_q = 1'b0;
   logic        in_ready, sfq_a, sfq_clk, busy;
   logic [15:0] bits_sent, err_count;

   int n_tests = 0;
   int n_fail  = 0;
   bit sb_q[$];

   always #5 clk = ~clk;

   sfq_not_stim_driver #(
      .DEPTH(DEPTH), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .Q_WIN_CYC(QWIN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
      .sfq_a(sfq_a), .sfq_clk(sfq_clk), .sfq_q(sfq_q), .busy(busy),
      .bits_sent(bits_sent), .err_count(err_count)
   );

   // Pulse monitor: pops the scoreboard on every clock pulse.
   int cyc = 0;
   int a_cyc = 0;
   int last_clk_cyc = -1;
   int n_clk_tog = 0;
   int strict_base = 0;
   bit strict_spacing = 0;
   bit a_pend = 0;
   logic mon_a = 1'b0, mon_c = 1'b0;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (!rst_n) begin
         a_pend = 0;
         last_clk_cyc = -1;
      end else begin
         if (sfq_a !== mon_a || sfq_clk !== mon_c) begin
            n_tests++;
            if (sfq_a !== mon_a && sfq_clk !== mon_c) begin
               n_fail++;
               $display("FAIL same_edge: a and clk toggled together at cycle %0d, want separate", cyc);
            end
         end
         if (sfq_a !== mon_a) begin
            n_tests++;
            if (a_pend) begin
               n_fail++;
               $display("FAIL double_a: second a pulse at cycle %0d, want one per bit", cyc);
            end
            a_pend = 1;
            a_cyc = cyc;
         end
         if (sfq_clk !== mon_c) begin
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_underflow: clock pulse at cycle %0d with no bit expected", cyc);
            end else begin
               bit exp_b;
               exp_b = sb_q.pop_front();
               if (a_pend !== exp_b) begin
                  n_fail++;
                  $display("FAIL bit_order: data pulse=%0b, want %0b", a_pend, exp_b);
               end else if (a_pend && (cyc - a_cyc != SETUP)) begin
                  n_fail++;
                  $display("FAIL setup_gap: a->clk %0d cycles, want %0d", cyc - a_cyc, SETUP);
               end
            end
            if (last_clk_cyc >= 0) begin
               n_tests++;
               if (strict_spacing && n_clk_tog > strict_base) begin
                  if (cyc - last_clk_cyc != PERIOD) begin
                     n_fail++;
                     $display("FAIL spacing: clk gap %0d, want %0d", cyc - last_clk_cyc, PERIOD);
                  end
               end else if (cyc - last_clk_cyc < PERIOD) begin
                  n_fail++;
                  $display("FAIL min_spacing: clk gap %0d, want >= %0d", cyc - last_clk_cyc, PERIOD);
               end
            end
            n_clk_tog++;
            last_clk_cyc = cyc;
            a_pend = 0;
         end
      end
      mon_a = sfq_a;
      mon_c = sfq_clk;
   end

   // NOT cell model driving sfq_q: 0 none, 1 ideal, stray_req injects one edge.
   int  model_mode = 0;
   bit  stray_req = 0;
   bit  m_pend = 0, m_a_seen = 0;
   logic m_a = 1'b0, m_c = 1'b0;

   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         sfq_q = 1'b0;
         m_pend = 0;
         m_a_seen = 0;
      end else begin
         if (m_pend || stray_req) sfq_q = ~sfq_q;
         m_pend = 0;
         stray_req = 0;
         if (sfq_a !== m_a) m_a_seen = 1;
         if (sfq_clk !== m_c) begin
            if (model_mode == 1 && !m_a_seen) m_pend = 1;
            m_a_seen = 0;
         end
      end
      m_a = sfq_a;
      m_c = sfq_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // Presents b and waits (bounded) for acceptance; leaves in_valid high.
   task automatic send(input bit b);
      int waited = 0;
      in_valid = 1'b1;
      in_bit = b;
      while (!in_ready && waited < 50) begin
         tick();
         waited++;
      end
      n_tests++;
      if (!in_ready) begin
         n_fail++;
         $display("FAIL send_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, waited);
      end else begin
         sb_q.push_back(b);
      end
      tick();
   endtask

   task automatic wait_idle();
      int waited = 0;
      while (busy && waited < 500) begin
         tick();
         waited++;
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_timeout: busy=%0b, want 0", busy);
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({sfq_a, sfq_clk, in_ready, busy} !== 4'b0010 || bits_sent !== 16'd0 ||
          err_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_state: a=%0b clk=%0b rdy=%0b busy=%0b sent=%0d err=%0d, want 0 0 1 0 0 0",
                  sfq_a, sfq_clk, in_ready, busy, bits_sent, err_count);
      end
      rst_n = 1'b1;
      tick();
      n_tests++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset: rdy=%0b busy=%0b, want 1 0", in_ready, busy);
      end
   endtask

   task automatic test_back_to_back();
      int a_at[$];
      int c_at[$];
      logic pa, pc;
      logic [15:0] base;
      base = bits_sent;
      pa = sfq_a;
      pc = sfq_clk;
      for (int k = 0; k <= 10; k++) begin
         if (k == 0) send(1'b1);
         else if (k == 1) send(1'b0);
         else begin
            in_valid = 1'b0;
            tick();
         end
         if (sfq_a !== pa) a_at.push_back(k);
         if (sfq_clk !== pc) c_at.push_back(k);
         pa = sfq_a;
         pc = sfq_clk;
      end
      n_tests++;
      if (a_at.size() != 1 || a_at[0] != 1) begin
         n_fail++;
         $display("FAIL b2b_a: %0d a toggles (first at T+%0d), want 1 at T+1",
                  a_at.size(), (a_at.size() > 0) ? a_at[0] : -1);
      end
      n_tests++;
      if (c_at.size() != 2 || c_at[0] != 1 + SETUP || c_at[1] != 1 + SETUP + PERIOD) begin
         n_fail++;
         $display("FAIL b2b_clk: %0d clk toggles (T+%0d, T+%0d), want T+%0d, T+%0d", c_at.size(),
                  (c_at.size() > 0) ? c_at[0] : -1, (c_at.size() > 1) ? c_at[1] : -1,
                  1 + SETUP, 1 + SETUP + PERIOD);
      end
      wait_idle();
      n_tests++;
      if (bits_sent !== base + 16'd2) begin
         n_fail++;
         $display("FAIL b2b_count: bits_sent=%0d, want %0d", bits_sent, base + 16'd2);
      end
   endtask

   task automatic test_fifo_full();
      localparam int Total = DEPTH + 4;
      bit pat[Total];
      int accepted = 0;
      int first_drop = -1;
      int guard = 0;
      logic [15:0] base;
      base = bits_sent;
      for (int i = 0; i < Total; i++) pat[i] = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      while (accepted < Total && guard < 400) begin
         in_bit = pat[accepted];
         if (in_ready) begin
            sb_q.push_back(pat[accepted]);
            accepted++;
         end else if (first_drop < 0) begin
            first_drop = accepted;
         end
         tick();
         guard++;
      end
      in_valid = 1'b0;
      // Two pops (T0+1, T0+1+PERIOD) happen before the FIFO reaches DEPTH entries.
      n_tests++;
      if (first_drop != DEPTH + 2) begin
         n_fail++;
         $display("FAIL full_ready: in_ready fell after %0d accepted, want %0d", first_drop, DEPTH + 2);
      end
      wait_idle();
      n_tests++;
      if (bits_sent !== base + 16'(Total)) begin
         n_fail++;
         $display("FAIL full_count: bits_sent=%0d, want %0d", bits_sent, base + 16'(Total));
      end
   endtask

   task automatic test_reset_mid_setup();
      logic pa;
      int waited = 0;
      apply_reset();
      send(1'b0);
      in_valid = 1'b0;
      wait_idle();
      pa = sfq_a;
      send(1'b1);
      in_valid = 1'b0;
      while (sfq_a === pa && waited < 20) begin
         tick();
         waited++;
      end
      n_tests++;
      if (sfq_a !== 1'b1 || bits_sent !== 16'd1) begin
         n_fail++;
         $display("FAIL pre_reset: a=%0b sent=%0d, want 1 1", sfq_a, bits_sent);
      end
      @(negedge clk);
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      n_tests++;
      if (sfq_a !== 1'b0 || sfq_clk !== 1'b0 || bits_sent !== 16'd0 || busy !== 1'b0 ||
          in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset: a=%0b clk=%0b sent=%0d busy=%0b rdy=%0b, want 0 0 0 0 1",
                  sfq_a, sfq_clk, bits_sent, busy, in_ready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) tick();
      n_tests++;
      if (sfq_clk !== 1'b0 || bits_sent !== 16'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_abandon: clk=%0b sent=%0d busy=%0b, want 0 0 0", sfq_clk, bits_sent, busy);
      end
   endtask

   task automatic test_checker();
`ifdef SFQ_NOT_CHECK_EN
      model_mode = 1;
      apply_reset();
      send(1'b0); send(1'b1); send(1'b0); send(1'b0);
      in_valid = 1'b0;
      wait_idle();
      repeat (8) tick();
      n_tests++;
      if (err_count !== 16'd0) begin
         n_fail++;
         $display("FAIL chk_ideal: err_count=%0d, want 0", err_count);
      end
      model_mode = 0;
      apply_reset();
      send(1'b0); send(1'b0); send(1'b1);
      in_valid = 1'b0;
      wait_idle();
      repeat (8) tick();
      n_tests++;
      if (err_count !== 16'd2) begin
         n_fail++;
         $display("FAIL chk_stuck: err_count=%0d, want 2", err_count);
      end
      stray_req = 1;
      repeat (6) tick();
      n_tests++;
      if (err_count !== 16'd3) begin
         n_fail++;
         $display("FAIL chk_stray: err_count=%0d, want 3", err_count);
      end
`else
      model_mode = 1;
      send(1'b0); send(1'b1);
      in_valid = 1'b0;
      stray_req = 1;
      wait_idle();
      repeat (6) tick();
      model_mode = 0;
      n_tests++;
      if (err_count !== 16'd0) begin
         n_fail++;
         $display("FAIL chk_off: err_count=%0d, want 0", err_count);
      end
`endif
   endtask

   task automatic test_spacing();
      localparam int NBits = 40;
      int base_tog;
      logic [15:0] base;
      apply_reset();
      base = bits_sent;
      base_tog = n_clk_tog;
      strict_base = n_clk_tog;
      strict_spacing = 1;
      for (int i = 0; i < NBits; i++) send(1'($urandom_range(0, 1)));
      in_valid = 1'b0;
      wait_idle();
      strict_spacing = 0;
      n_tests++;
      if (n_clk_tog - base_tog != NBits || bits_sent !== base + 16'(NBits)) begin
         n_fail++;
         $display("FAIL spacing_count: clk toggles=%0d sent=%0d, want %0d %0d",
                  n_clk_tog - base_tog, bits_sent - base, NBits, NBits);
      end
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: %0d bits never emitted, want 0", sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_fifo_full();
      test_reset_mid_setup();
      test_checker();
      test_spacing();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
